// File: rtl/vdc_signals_v_if.sv
// Register, strobe and timing-output bundle between the horizontal stage, the register file
// and the VDC vertical timing generator.
interface vdc_signals_v_if;
  logic       enable;
  logic       hEnd;
  logic [7:0] reg_vt;
  logic [4:0] reg_va;
  logic [7:0] reg_vd;
  logic [7:0] reg_vp;
  logic [3:0] reg_vw;
  logic [4:0] reg_ctv;
  logic [1:0] reg_im;
  logic [7:0] row;
  logic [4:0] line;
  logic       newLine;
  logic       newFrame;
  logic       vdispen;
  logic       vsync;
  logic       vblank;
  logic       field;

  modport master (
    output enable, hEnd, reg_vt, reg_va, reg_vd, reg_vp, reg_vw, reg_ctv, reg_im,
    input  row, line, newLine, newFrame, vdispen, vsync, vblank, field
  );

  modport slave (
    input  enable, hEnd, reg_vt, reg_va, reg_vd, reg_vp, reg_vw, reg_ctv, reg_im,
    output row, line, newLine, newFrame, vdispen, vsync, vblank, field
  );
endinterface

// File: rtl/vdc_signals_v.sv
// C128 VDC vertical timing: scan lines, character rows, adjust lines, vsync/vblank/vdispen.
// Define VDC_INTERLACE_EN to enable field toggling and the extra odd-field adjust line.
module vdc_signals_v #(
  parameter int unsigned VBLANK_EXTRA = 2
) (
  input logic       clk,
  input logic       reset,
  vdc_signals_v_if.slave bus
);

  localparam int unsigned VbW = (VBLANK_EXTRA > 0) ? $clog2(VBLANK_EXTRA + 1) : 1;

  typedef enum logic [0:0] {StRow, StAdj} state_e;

  state_e         state_q, state_d;
  logic [7:0]     row_q, row_d;
  logic [4:0]     line_q, line_d;
  logic [4:0]     vs_cnt_q, vs_cnt_d;
  logic [VbW-1:0] vb_cnt_q, vb_cnt_d;
  logic           vsync_q, vsync_d;
  logic           field_q, field_d;
  logic           vdispen_q, new_line_q, new_frame_q, vblank_q;
  logic [5:0]     adj_lines;
  logic           wrap;
  logic           vs_start;

`ifdef VDC_INTERLACE_EN
  // Odd field of an interlaced frame gets one extra scan line.
  assign adj_lines = {1'b0, bus.reg_va} + {5'd0, bus.reg_im[0] & field_q};
`else
  logic unused_im;
  assign unused_im = ^bus.reg_im;
  assign adj_lines = {1'b0, bus.reg_va};
`endif

  always_comb begin
    row_d   = row_q;
    line_d  = line_q;
    state_d = state_q;
    wrap    = 1'b0;
    unique case (state_q)
      StRow: begin
        if (line_q < bus.reg_ctv) begin
          line_d = line_q + 5'd1;
        end else begin
          line_d = 5'd0;
          if (row_q < bus.reg_vt) begin
            row_d = row_q + 8'd1;
          end else if (adj_lines == 6'd0) begin
            wrap = 1'b1;
          end else begin
            state_d = StAdj;
          end
        end
      end
      StAdj: begin
        if (({1'b0, line_q} + 6'd1) >= adj_lines) wrap = 1'b1;
        else line_d = line_q + 5'd1;
      end
      default: ;
    endcase
    if (wrap) begin
      row_d   = 8'd0;
      line_d  = 5'd0;
      state_d = StRow;
    end

`ifdef VDC_INTERLACE_EN
    field_d = wrap ? ~field_q : field_q;
`else
    field_d = 1'b0;
`endif

    vs_start = (state_d == StRow) && (row_d == bus.reg_vp) && (line_d == 5'd0);
    vs_cnt_d = vs_cnt_q;
    vsync_d  = vsync_q;
    vb_cnt_d = vb_cnt_q;
    if (!vsync_q && vb_cnt_q != '0) vb_cnt_d = vb_cnt_q - 1'b1;
    // A running vsync ignores new start conditions; no retrigger.
    if (vs_cnt_q > 5'd1) begin
      vs_cnt_d = vs_cnt_q - 5'd1;
    end else if (vs_cnt_q == 5'd1) begin
      vs_cnt_d = 5'd0;
      vsync_d  = 1'b0;
    end else if (vs_start) begin
      vs_cnt_d = (bus.reg_vw == 4'd0) ? 5'd16 : {1'b0, bus.reg_vw};
      vb_cnt_d = VbW'(VBLANK_EXTRA);
      vsync_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StRow;
      row_q       <= 8'd0;
      line_q      <= 5'd0;
      vs_cnt_q    <= 5'd0;
      vb_cnt_q    <= '0;
      vsync_q     <= 1'b0;
      field_q     <= 1'b0;
      vdispen_q   <= 1'b0;
      new_line_q  <= 1'b0;
      new_frame_q <= 1'b0;
      vblank_q    <= 1'b0;
    end else if (bus.enable) begin
      if (bus.hEnd) begin
        state_q     <= state_d;
        row_q       <= row_d;
        line_q      <= line_d;
        vs_cnt_q    <= vs_cnt_d;
        vb_cnt_q    <= vb_cnt_d;
        vsync_q     <= vsync_d;
        field_q     <= field_d;
        vdispen_q   <= (state_d == StRow) && (row_d < bus.reg_vd);
        new_line_q  <= 1'b1;
        new_frame_q <= wrap;
        vblank_q    <= vsync_d | (vb_cnt_d != '0);
      end else begin
        new_line_q  <= 1'b0;
        new_frame_q <= 1'b0;
      end
    end
  end

  assign bus.row      = row_q;
  assign bus.line     = line_q;
  assign bus.newLine  = new_line_q;
  assign bus.newFrame = new_frame_q;
  assign bus.vdispen  = vdispen_q;
  assign bus.vsync    = vsync_q;
  assign bus.vblank   = vblank_q;
  assign bus.field    = field_q;

endmodule

// File: tb/tb_vdc_signals_v.sv
// Bench for vdc_signals_v: directed and randomized line pulses against a positional frame model.
module tb_vdc_signals_v;

  localparam int VbExtra = 2;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad = 0;

  vdc_signals_v_if bus ();

  vdc_signals_v #(.VBLANK_EXTRA(VbExtra)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  // Model: frame position p counts scan lines from frame start, adjust lines last.
  int m_vt, m_ctv, m_va, m_vd, m_vp, m_vw, m_im;
  int m_p, m_since;
  bit m_started, m_field, m_nl, m_nf, m_hit;

  function automatic int adj_len();
`ifdef VDC_INTERLACE_EN
    return m_va + ((m_im[0] == 1'b1 && m_field) ? 1 : 0);
`else
    return m_va;
`endif
  endfunction

  function automatic int vs_width();
    return (m_vw == 0) ? 16 : m_vw;
  endfunction

  function automatic void pos(input int p, output int r, output int l, output bit a);
    int body;
    body = (m_vt + 1) * (m_ctv + 1);
    if (p < body) begin
      r = p / (m_ctv + 1);
      l = p % (m_ctv + 1);
      a = 1'b0;
    end else begin
      r = m_vt;
      l = p - body;
      a = 1'b1;
    end
  endfunction

  function automatic void model_reset();
    m_p = 0; m_since = 0; m_started = 0; m_field = 0; m_nl = 0; m_nf = 0; m_hit = 0;
  endfunction

  function automatic void model_hend();
    int len, r, l;
    bit a, elig;
    len  = (m_vt + 1) * (m_ctv + 1) + adj_len();
    elig = !m_started || (m_since >= vs_width());
    m_p++;
    if (m_p >= len) begin
      m_p  = 0;
      m_nf = 1;
`ifdef VDC_INTERLACE_EN
      m_field = !m_field;
`endif
    end else begin
      m_nf = 0;
    end
    m_nl  = 1;
    m_hit = 1;
    if (m_started) m_since++;
    pos(m_p, r, l, a);
    if (elig && !a && r == m_vp && l == 0) begin
      m_started = 1;
      m_since   = 0;
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    int r, l;
    bit a;
    pos(m_p, r, l, a);
    chk("row", 32'(bus.row), 32'(r));
    chk("line", 32'(bus.line), 32'(l));
    chk("newLine", 32'(bus.newLine), 32'(m_nl));
    chk("newFrame", 32'(bus.newFrame), 32'(m_nf));
    chk("vdispen", 32'(bus.vdispen), 32'(m_hit && !a && r < m_vd));
    chk("vsync", 32'(bus.vsync), 32'(m_started && m_since < vs_width()));
    chk("vblank", 32'(bus.vblank), 32'(m_started && m_since < vs_width() + VbExtra));
    chk("field", 32'(bus.field), 32'(m_field));
  endtask

  task automatic tick(input bit en, input bit h);
    bus.enable = en;
    bus.hEnd   = h;
    @(posedge clk);
    if (en) begin
      if (h) model_hend();
      else begin
        m_nl = 0;
        m_nf = 0;
      end
    end
    #1;
  endtask

  task automatic apply_cfg(input int vt, input int ctv, input int va, input int vd,
                           input int vp, input int vw, input int im);
    m_vt = vt; m_ctv = ctv; m_va = va; m_vd = vd; m_vp = vp; m_vw = vw; m_im = im;
    bus.reg_vt  = 8'(vt);
    bus.reg_ctv = 5'(ctv);
    bus.reg_va  = 5'(va);
    bus.reg_vd  = 8'(vd);
    bus.reg_vp  = 8'(vp);
    bus.reg_vw  = 4'(vw);
    bus.reg_im  = 2'(im);
    reset       = 1'b1;
    bus.enable  = 1'($urandom_range(0, 1));
    bus.hEnd    = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    check_all();
  endtask

  task automatic run_rand(input int n);
    for (int i = 0; i < n; i++) begin
      int idle;
      idle = $urandom_range(0, 2);
      for (int j = 0; j < idle; j++) begin
        bit en;
        en = ($urandom_range(0, 3) != 0);
        tick(en, en ? 1'b0 : 1'($urandom_range(0, 1)));
        check_all();
      end
      tick(1'b1, 1'b1);
      check_all();
    end
  endtask

  initial begin
    reset      = 1'b1;
    bus.enable = 1'b0;
    bus.hEnd   = 1'b0;

    // Basic row/line stepping, then adjust lines, then vsync/vblank window.
    apply_cfg(3, 1, 0, 2, 200, 3, 0);
    for (int i = 0; i < 8; i++) begin
      tick(1'b1, 1'b1);
      check_all();
    end
    tick(1'b1, 1'b0);
    check_all();
    apply_cfg(3, 1, 3, 2, 200, 3, 0);
    run_rand(24);
    apply_cfg(3, 1, 0, 2, 2, 3, 0);
    run_rand(20);

    // 16-line vsync spanning the frame wrap.
    apply_cfg(3, 1, 1, 2, 2, 0, 0);
    run_rand(40);

    // Enable held low with hEnd high: everything frozen.
    for (int i = 0; i < 10; i++) begin
      tick(1'b0, 1'b1);
      check_all();
    end

    // Reset mid-frame with enable low.
    reset      = 1'b1;
    bus.enable = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    chk("rst_row", 32'(bus.row), 32'd0);
    chk("rst_vsync", 32'(bus.vsync), 32'd0);
    chk("rst_vblank", 32'(bus.vblank), 32'd0);
    check_all();

    // Lowering the vertical total mid-frame ends the frame at the current row.
    apply_cfg(7, 1, 0, 3, 9, 2, 0);
    for (int i = 0; i < 10; i++) tick(1'b1, 1'b1);
    chk("lower_pre_row", 32'(bus.row), 32'd5);
    bus.reg_vt = 8'd2;
    tick(1'b1, 1'b1);
    chk("lower_row", 32'(bus.row), 32'd5);
    chk("lower_line", 32'(bus.line), 32'd1);
    tick(1'b1, 1'b1);
    chk("lower_wrap_row", 32'(bus.row), 32'd0);
    chk("lower_wrap_line", 32'(bus.line), 32'd0);
    chk("lower_wrap_nf", 32'(bus.newFrame), 32'd1);

    // Interlace: odd fields one adjust line longer when the feature is built in.
    apply_cfg(1, 0, 2, 1, 0, 1, 3);
    run_rand(30);

    for (int k = 0; k < 5; k++) begin
      apply_cfg($urandom_range(0, 6), $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 8), $urandom_range(0, 7), $urandom_range(0, 5),
                $urandom_range(0, 3));
      run_rand(60);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vdc_signals_v.md
Name: vdc_signals_v

Overview:
- Vertical timing generator for the C128 VDC; sits directly downstream of the horizontal signal generator and consumes its end-of-line pulse.
- Counts scan lines within character rows, and character rows within a frame.
- Handles the vertical total adjust lines.
- Produces vertical display enable, vsync, vblank and line/frame strobes for the fetch and pixel stages.

Parameters:
- VBLANK_EXTRA, 2: scan lines vblank stays asserted after vsync deasserts.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- enable  in  1  pixel clock enable; all state frozen when low
- hEnd  in  1  one-enable-cycle pulse on last pixel of last column of a line
- reg_vt  in  8  R4 vertical total, rows minus 1
- reg_va  in  5  R5[4:0] vertical total adjust, extra scan lines
- reg_vd  in  8  R6 vertical displayed rows
- reg_vp  in  8  R7 vsync position, row
- reg_vw  in  4  R3[7:4] vsync width in lines; 0 means 16
- reg_ctv  in  5  R9[4:0] character total vertical, lines minus 1
- reg_im  in  2  R8[1:0] interlace mode
- row  out  8  current character row
- line  out  5  current scan line within row, or adjust line index
- newLine  out  1  pulses first enable cycle of each line
- newFrame  out  1  pulses first enable cycle of each frame, together with newLine
- vdispen  out  1  vertical display enable
- vsync  out  1  vertical sync
- vblank  out  1  vertical blanking
- field  out  1  interlace field, 0 = even

Behaviour:
- All outputs and state are registered, updated only when enable=1; hEnd is evaluated only when enable=1.
- Reset values: row=0, line=0, state=S_ROW, vsCount=0, vbCount=0, newLine=0, newFrame=0, vdispen=0, vsync=0, vblank=0, field=0.
- newLine/newFrame default to 0 on every enabled cycle without hEnd, so each pulse lasts exactly one enable cycle.
- States: S_ROW (character rows) and S_ADJ (adjust lines).
- On hEnd in S_ROW:
  - line<reg_ctv: line+1.
  - Otherwise: line=0.
    - row<reg_vt: row+1.
    - row>=reg_vt and adjLines=0: frame wrap.
    - Otherwise: enter S_ADJ with line=0.
  - The >= compares make a register lowered mid-frame end the row/frame immediately; no runaway to 255.
- On hEnd in S_ADJ:
  - line+1>=adjLines: frame wrap.
  - Otherwise: line+1.
  - row holds reg_vt's last value during S_ADJ.
- Frame wrap: row=0, line=0, state=S_ROW, newFrame=1.
- newLine=1 on every hEnd.
- adjLines = reg_va, extended per Optional Feature.
- vdispen is registered on hEnd from next-state values: 1 iff next_state==S_ROW and next_row<reg_vd.
  - reg_vd=0: never set.
  - reg_vd>reg_vt: high for all rows, low during S_ADJ.
- vsync start: on hEnd whose next state is S_ROW, next_row==reg_vp, next_line==0 and vsCount==0.
  - Load vsCount = (reg_vw==0 ? 16 : reg_vw) and vbCount = VBLANK_EXTRA.
  - vsync=1 from that line.
- vsync continuation, on each later hEnd:
  - vsCount>1: decrement.
  - vsCount==1: vsCount=0, vsync=0.
- vsync continues across row and frame boundaries.
- A start condition while vsCount!=0 is ignored, with no retrigger.
- reg_vp>reg_vt: vsync never asserts.
- vblank = vsync OR (vbCount!=0).
  - vbCount decrements on hEnd only while vsync=0.
  - Held at 0 when VBLANK_EXTRA=0.
- Reset mid-frame returns all state to reset values on the next clk, regardless of enable.

Optional Feature:
- Macro VDC_INTERLACE_EN.
- Defined:
  - field toggles at every frame wrap.
  - When reg_im[0]=1 and field=1 (odd field), adjLines = reg_va+1, so the odd field is one scan line longer.
  - Interlace sync offset is produced downstream from field.
- Undefined:
  - field tied to 0.
  - reg_im ignored.
  - adjLines = reg_va.

Test Plan:
- Reset, then reg_vt=3, reg_ctv=1, reg_va=0, reg_vd=2; pulse hEnd 8 times -> (row,line) steps (0,1),(1,0),(1,1),(2,0),(2,1),(3,0),(3,1),(0,0); newFrame only on the 8th; vdispen=1 for rows 0-1, 0 for rows 2-3.
- Same settings with reg_va=3 -> after row 3 line 1, state S_ADJ with line 0,1,2, vdispen=0; wrap on the 11th hEnd of the frame.
- reg_vp=2, reg_vw=3, VBLANK_EXTRA=2 -> vsync high for exactly 3 lines starting row 2 line 0; vblank high for 5 lines; reg_vw=0 -> vsync high for 16 lines, spanning the frame wrap.
- Mid-frame at row 5, write reg_vt=2 -> frame wraps at end of current row (row 5, line=reg_ctv); no rows 6..255 traversed.
- enable held low for 10 clocks with hEnd=1 -> no counter change, pulses hold; assert reset mid-frame -> all outputs 0 next clk.
- With VDC_INTERLACE_EN, reg_im=2'b11, reg_va=2 -> field alternates each frame; odd frames have 3 adjust lines, even frames 2.
